// File: rtl/serial_tx_engine.sv
// serial_tx_engine: frames a parallel payload as start bit, LSB-first data, optional parity and stop bits
module serial_tx_engine #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] DATA_MAX = IDX_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0] STOP_MAX = IDX_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic              par, par_n, tx_n, done_n, bit_end, last;

   assign tx_ready = state == IDLE;
   assign busy     = state != IDLE;

   // state register; an asserted reset abandons any frame in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
         par   <= 1'b0;
         tx    <= 1'b1;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         shreg <= shreg_n;
         par   <= par_n;
         tx    <= tx_n;
         done  <= done_n;
      end
   end

   // next state, bit timing and the registered line value derived from the next state
   always_comb begin
      bit_end = cnt == CNT_MAX;
      last    = bit_end && idx == (state == STOP ? STOP_MAX : DATA_MAX);
      state_n = state;
      case (state)
         IDLE:    if (tx_valid) state_n = START;
         START:   if (bit_end) state_n = DATA;
         DATA:    if (last) state_n = (PARITY_EN != 0) ? PARITY : STOP;
         PARITY:  if (bit_end) state_n = STOP;
         STOP:    if (last) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      cnt_n   = (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      idx_n   = (state_n != state) ? '0 : bit_end ? idx + 1'b1 : idx;
      shreg_n = (state == IDLE && tx_valid) ? tx_data : (state == DATA && bit_end) ? shreg >> 1 : shreg;
      par_n   = (state == IDLE && tx_valid) ? (^tx_data) ^ (PARITY_ODD != 0) : par;
      tx_n    = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : state_n == PARITY ? par : 1'b1;
      done_n  = state == STOP && state_n == IDLE;
   end
endmodule

// File: tb/tb_serial_tx_engine.sv
// tb_serial_tx_engine: scoreboard bench over five parameter sets of serial_tx_engine
module tb_serial_tx_engine;
   localparam int N = 5;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_fin = 0;

   typedef struct {
      logic [31:0] fb;
      int          len;
      int          hs;
      bit          ab;
   } exp_t;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic int c_dw(input int i);  return i == 4 ? 5 : 8; endfunction
   function automatic int c_cpb(input int i); return i == 4 ? 2 : 4; endfunction
   function automatic int c_par(input int i); return (i == 1 || i == 2) ? 1 : 0; endfunction
   function automatic int c_odd(input int i); return i == 2 ? 1 : 0; endfunction
   function automatic int c_stp(input int i); return i == 3 ? 2 : 1; endfunction

   // directed payload, its line pattern (bit k = k-th bit on the wire) and frame length
   function automatic logic [15:0] c_dd(input int i);
      case (i)
         0: return 16'hA5;
         1, 2: return 16'h07;
         3: return 16'h00;
         default: return 16'h13;
      endcase
   endfunction

   function automatic logic [31:0] c_fb(input int i);
      case (i)
         0: return 32'h34A;
         1: return 32'h60E;
         2: return 32'h40E;
         3: return 32'h600;
         default: return 32'h66;
      endcase
   endfunction

   function automatic int c_len(input int i);
      case (i)
         0: return 40;
         1, 2, 3: return 44;
         default: return 14;
      endcase
   endfunction

   for (genvar g = 0; g < N; g++) begin : u
      localparam int DW  = c_dw(g);
      localparam int CPB = c_cpb(g);
      localparam int PE  = c_par(g);
      localparam int PO  = c_odd(g);
      localparam int SB  = c_stp(g);
      localparam int LEN = (1 + DW + PE + SB) * CPB;

      logic          rst_n, valid, ready, tx, busy, done;
      logic [DW-1:0] data;
      exp_t          q[$];

      serial_tx_engine #(
         .DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SB)
      ) dut (
         .clk(clk), .rst_n(rst_n), .tx_data(data), .tx_valid(valid),
         .tx_ready(ready), .tx(tx), .busy(busy), .done(done)
      );

      function automatic logic [31:0] model(input logic [15:0] d);
         logic [31:0] f;
         f = '1;
         f[0] = 1'b0;
         for (int i = 0; i < DW; i++) f[1 + i] = d[i];
         if (PE != 0) f[1 + DW] = (^(d & 16'((1 << DW) - 1))) ^ (PO != 0);
         return f;
      endfunction

      task automatic send(input logic [15:0] d, input logic [31:0] fb, input int len,
                          input bit hold, input bit ab, output int hs);
         int t;
         t = 0;
         data  = d[DW-1:0];
         valid = 1'b1;
         while (!ready && t < 200) begin
            @(negedge clk);
            t++;
         end
         hs = cyc + 1;
         chk("handshake_wait", 64'(ready), 64'(1));
         if (ready) q.push_back('{fb, len, hs, ab});
         @(negedge clk);
         if (!hold) valid = 1'b0;
      endtask

      initial begin : stim
         int          h1, h2, t;
         logic [15:0] r;
         bit          dn, hold, prev_hold;
         rst_n = 1'b0;
         valid = 1'b0;
         data  = '0;
         repeat (3) @(negedge clk);
         chk("reset_outputs", 64'({tx, ready, busy, done}), 64'(4'b1100));
         rst_n = 1'b1;
         send(c_dd(g), c_fb(g), c_len(g), 1'b0, 1'b0, h1);
         send(16'h3C, model(16'h3C), LEN, 1'b1, 1'b0, h1);
         send(16'hC3, model(16'hC3), LEN, 1'b0, 1'b0, h2);
         chk("back_to_back_gap", 64'(h2 - h1), 64'(LEN + 1));
         send(16'h10, model(16'h10), LEN, 1'b0, 1'b1, h1);
         while (cyc < h1 + 4 * CPB + 1) @(negedge clk);
         chk("pre_abort_line", 64'({tx, busy}), 64'(2'b01));
         #1 rst_n = 1'b0;
         #1 chk("abort_async", 64'({tx, ready, busy, done}), 64'(4'b1100));
         dn = 1'b0;
         repeat (2) begin
            @(negedge clk);
            dn |= done;
         end
         #1 rst_n = 1'b1;
         send(16'h5A, model(16'h5A), LEN, 1'b0, 1'b0, h2);
         chk("no_done_on_abort", 64'(dn), 64'(0));
         prev_hold = 1'b0;
         for (int i = 0; i < 12; i++) begin
            r    = 16'($urandom);
            hold = (i != 11) && ($urandom_range(0, 1) == 1);
            if (!prev_hold) repeat ($urandom_range(0, 3)) @(negedge clk);
            send(r, model(r), LEN, hold, 1'b0, h1);
            prev_hold = hold;
         end
         t = 0;
         while (q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
         end
         repeat (LEN + 4) @(negedge clk);
         chk("scoreboard_drained", 64'(q.size()), 64'(0));
         n_fin++;
      end

      initial begin : mon
         exp_t        e;
         logic [63:0] got, want;
         int          ok, pend;
         bit          ab;
         pend = -1;
         forever begin
            @(negedge clk);
            if (cyc == pend) chk("done_width", 64'(done), 64'(0));
            if (rst_n && !tx) begin
               chk("frame_expected", 64'(q.size() != 0), 64'(1));
               if (q.size() != 0) begin
                  e = q.pop_front();
                  chk("start_latency", 64'(cyc - e.hs), 64'(0));
                  got  = '0;
                  want = '0;
                  ok   = 0;
                  ab   = 1'b0;
                  for (int k = 0; k < e.len; k++) begin
                     if (k > 0) @(negedge clk);
                     if (!rst_n) begin
                        ab = 1'b1;
                        break;
                     end
                     got[k]  = tx;
                     want[k] = e.fb[k / CPB];
                     ok += int'(busy && !ready && !done);
                  end
                  chk("abort_flag", 64'(ab), 64'(e.ab));
                  if (!ab) begin
                     chk("frame_line", got, want);
                     chk("frame_status", 64'(ok), 64'(e.len));
                     @(negedge clk);
                     chk("done_cycle", 64'({tx, ready, busy, done}), 64'(4'b1101));
                     pend = cyc + 1;
                  end
               end
            end
         end
      end
   end

   initial begin : main
      int t;
      t = 0;
      while (n_fin < N && t < 20000) begin
         @(negedge clk);
         t++;
      end
      chk("run_complete", 64'(n_fin), 64'(N));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
